// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: shared state encoding and default sizes for the FIFO write/read scheduler
package fifo_sched_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_e;
  localparam int FIFO_DEPTH    = 16;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick: combinational round-robin search for the first set request at or after rr_ptr_i
//   req_i    : per-requester request vector
//   rr_ptr_i : search start index (must be < NUM_REQ)
//   pick_o   : one-hot winner, zero when nothing requests
//   valid_o  : any request set
module fifo_rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      rr_ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);
  logic [PW:0] s;
  // Walk from the farthest candidate back to rr_ptr_i so the nearest set request wins.
  always_comb begin
    pick_o = '0;
    s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = {1'b0, rr_ptr_i} + (PW+1)'(k);
      s = (s >= (PW+1)'(NUM_REQ)) ? s - (PW+1)'(NUM_REQ) : s;
      if (req_i[s[PW-1:0]]) pick_o = NUM_REQ'(1) << s;
    end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/fifo_sched.sv
// fifo_sched: round-robin write arbiter and read/write slot scheduler in front of a 16x8 FIFO
//   clk, rst        : clock, asynchronous active-low reset
//   req, req_data   : producer requests and packed data (slice i = [i*DATA_W +: DATA_W])
//   grant, ack      : registered one-hot owner, per-producer transfer strobe
//   rd_req, rd_ack  : consumer read request and issue strobe (FIFO data valid next cycle)
//   fifo_*          : FIFO write/read enables, write data, full/empty status
//   busy            : scheduler not idle
//   FIFO_SCHED_BURST_EN defined: a grant lasts up to MAX_BURST words; undefined: one word
module fifo_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      rd_req,
  output logic                      rd_ack,
  output logic                      fifo_write_en,
  output logic                      fifo_read_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  output logic                      busy
);
  localparam int PW = $clog2(NUM_REQ);
  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d, owner;
  logic               prefer_rd_q, prefer_rd_d;
  logic               any_req, wr_pend, rd_pend, own_req, last_word, wr_exit;

  fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (req),
    .rr_ptr_i(rr_ptr_q),
    .pick_o  (pick),
    .valid_o (any_req)
  );

  assign wr_pend = any_req & ~fifo_full;
  assign rd_pend = rd_req & ~fifo_empty;
  assign own_req = |(grant_q & req);

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant_q[i]) owner = PW'(i);
  end

`ifdef FIFO_SCHED_BURST_EN
  localparam int BW = $clog2(MAX_BURST) + 1;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  assign last_word = |ack & (burst_cnt_q == BW'(MAX_BURST - 1));
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == S_IDLE) burst_cnt_d = '0;
    else if (state_q == S_WRITE) burst_cnt_d = burst_cnt_q + BW'(|ack);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) burst_cnt_q <= '0;
    else burst_cnt_q <= burst_cnt_d;
  end
`else
  assign last_word = |ack;
`endif

  // A grant ends when its owner lets go, the FIFO fills, or its word budget is spent.
  assign wr_exit = ~own_req | fifo_full | last_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      prefer_rd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      prefer_rd_q <= prefer_rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    prefer_rd_d = prefer_rd_q;
    case (state_q)
      S_IDLE: begin
        state_d = (wr_pend & rd_pend) ? (prefer_rd_q ? S_READ : S_WRITE) :
                  wr_pend ? S_WRITE : rd_pend ? S_READ : S_IDLE;
        grant_d = (state_d == S_WRITE) ? pick : '0;
      end
      S_WRITE: begin
        if (wr_exit) begin
          state_d     = S_IDLE;
          grant_d     = '0;
          rr_ptr_d    = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          prefer_rd_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        prefer_rd_d = 1'b0;
      end
    endcase
  end

  // Writes and reads live in disjoint states, so both enables can never be high together.
  always_comb begin
    grant         = grant_q;
    ack           = (state_q == S_WRITE) ? (grant_q & req & {NUM_REQ{~fifo_full}}) : '0;
    fifo_write_en = |ack;
    rd_ack        = (state_q == S_READ) & rd_pend;
    fifo_read_en  = rd_ack;
    busy          = state_q != S_IDLE;
    fifo_data_in  = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant_q[i]) fifo_data_in = req_data[i*DATA_W +: DATA_W];
  end
endmodule

// File: tb/tb_fifo_sched.sv
// tb_fifo_sched: directed self-checking bench for fifo_sched with a behavioural 16x8 FIFO
module tb_fifo_sched;
`ifdef FIFO_SCHED_BURST_EN
  localparam int BL = 4;
`else
  localparam int BL = 1;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  grant, ack;
  logic        rd_req = 1'b0, rd_ack;
  logic        fifo_write_en, fifo_read_en, fifo_full, fifo_empty, busy;
  logic [7:0]  fifo_data_in;
  logic [7:0]  fifo_data_out = '0;
  logic        fclr = 1'b1;
  logic [7:0]  mem [16];
  int          wp = 0, rp = 0, cnt = 0;
  int          n_asrt = 0, n_fail = 0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  fifo_sched #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant), .ack(ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .fifo_write_en(fifo_write_en), .fifo_read_en(fifo_read_en),
    .fifo_data_in(fifo_data_in), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .busy(busy)
  );

  // Behavioural FIFO: a write wins over a simultaneous read; fclr empties it.
  always @(posedge clk) begin
    if (fclr) begin
      wp <= 0; rp <= 0; cnt <= 0;
    end else if (fifo_write_en) begin
      if (cnt < 16) begin mem[wp] <= fifo_data_in; wp <= (wp + 1) % 16; cnt <= cnt + 1; end
    end else if (fifo_read_en && cnt > 0) begin
      fifo_data_out <= mem[rp]; rp <= (rp + 1) % 16; cnt <= cnt - 1;
    end
  end
  assign fifo_full  = (cnt == 16);
  assign fifo_empty = (cnt == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    #1;
    chk("inv_wr_and_rd", {31'b0, fifo_write_en & fifo_read_en}, 0);
    chk("inv_wr_while_full", {31'b0, fifo_write_en & fifo_full}, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait();
    req = '0; rd_req = 1'b0;
    step(); step();
    #1;
    chk("idle_busy", busy, 0);
  endtask

  function automatic logic [7:0] pdata(input logic [3:0] oh);
    pdata = 8'h00;
    for (int i = 0; i < 4; i++) if (oh[i]) pdata = 8'(8'h11 * (i + 1));
  endfunction

  task automatic rd_words(input int n);
    int got = 0, cyc = 0;
    rd_req = 1'b1;
    while (got < n && cyc < 4 * n + 8) begin
      #1;
      if (rd_ack) begin
        step();
        chk("rd_data", fifo_data_out, exp_q.pop_front());
        got++;
      end else step();
      cyc++;
    end
    rd_req = 1'b0;
    chk("rd_count", got, n);
  endtask

  task automatic write_words(input int idx, input int n, input logic [7:0] base);
    int k = 0, cyc = 0;
    req = 4'(1 << idx);
    while (k < n && cyc < 8 * n + 8) begin
      req_data[idx*8 +: 8] = base + 8'(k);
      #1;
      if (ack[idx]) begin
        chk("ww_data", fifo_data_in, base + 8'(k));
        exp_q.push_back(base + 8'(k));
        k++;
      end
      step();
      cyc++;
    end
    chk("ww_count", k, n);
  endtask

  task automatic grant_seq(input logic [3:0] r, input logic [31:0] gs, input int ng);
    req = r; req_data = 32'h44332211; fclr = 1'b1;
    for (int g = 0; g < ng; g++) begin
      #1;
      chk("gs_idle_grant", grant, 0);
      step();
      for (int b = 0; b < BL; b++) begin
        #1;
        chk("gs_grant", grant, gs[g*4 +: 4]);
        chk("gs_ack", ack, gs[g*4 +: 4]);
        chk("gs_data", fifo_data_in, pdata(gs[g*4 +: 4]));
        step();
      end
    end
    req = '0; fclr = 1'b0;
  endtask

  initial begin
    int k, w, p;
    logic [7:0] d;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_ack", ack, 0);
    chk("rst_wr_en", fifo_write_en, 0);
    chk("rst_rd_en", fifo_read_en, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_in", fifo_data_in, 0);
    #5 rst = 1'b1;
    @(posedge clk);
    #1;
    fclr = 1'b0;

    // 1: one producer builds six words; bursts separated by one idle cycle
    req = 4'b0001; k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      req_data[7:0] = 8'hA0 + 8'(k);
      #1;
      chk("t1_ack", ack, ((c % (BL + 1)) != 0) ? 4'b0001 : 4'b0000);
      if (ack[0]) begin
        chk("t1_data", fifo_data_in, 8'hA0 + 8'(k));
        exp_q.push_back(8'hA0 + 8'(k));
        k++;
      end
      step();
    end
    chk("t1_words", k, 6);
    idle_wait();
    rd_words(6);
    idle_wait();

    // 2: all producers requesting; rr_ptr is 1 after test 1
    grant_seq(4'b1111, 32'h00021842, 5);
    idle_wait();

    // 3: fill the FIFO, writes blocked while full, reads still scheduled
    write_words(3, 16, 8'h30);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_full", fifo_full, 1);
      chk("t3_no_ack", ack, 0);
      chk("t3_no_wr", fifo_write_en, 0);
      chk("t3_no_grant", grant, 0);
      step();
    end
    rd_req = 1'b1;
    #1;
    chk("t3_rd_idle", rd_ack, 0);
    step();
    req = '0;
    #1;
    chk("t3_rd_ack", rd_ack, 1);
    chk("t3_rd_en", fifo_read_en, 1);
    step();
    rd_req = 1'b0;
    #1;
    chk("t3_first_word", fifo_data_out, exp_q.pop_front());
    rd_words(15);
    chk("t3_empty", fifo_empty, 1);
    idle_wait();

    // 4: write burst / idle / read / idle alternation with 8 words stored
    write_words(2, 8, 8'h40);
    idle_wait();
    req = 4'b0100; rd_req = 1'b1; w = 0;
    for (int c = 0; c < 2 * (BL + 3); c++) begin
      p = c % (BL + 3);
      req_data[23:16] = 8'h48 + 8'(w);
      #1;
      chk("t4_rd_ack", rd_ack, p == 1);
      chk("t4_ack", ack, (p >= 3) ? 4'b0100 : 4'b0000);
      if (ack[2]) begin exp_q.push_back(8'h48 + 8'(w)); w++; end
      if (p == 2) begin
        d = exp_q.pop_front();
        chk("t4_rd_data", fifo_data_out, d);
      end
      step();
    end
    idle_wait();
    rd_words(exp_q.size());
    idle_wait();

    // 5: asynchronous reset in the middle of a grant
    fclr = 1'b1;
    req = 4'b0100; req_data = 32'h44332211;
    #1;
    chk("t5_pre_grant", grant, 0);
    step();
    #1;
    chk("t5_grant", grant, 4'b0100);
    chk("t5_ack", ack, 4'b0100);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_wr", fifo_write_en, 0);
    chk("t5_rst_busy", busy, 0);
    step();
    chk("t5_held_grant", grant, 0);
    rst = 1'b1;
    req = 4'b1010;
    #1;
    chk("t5_rel_grant", grant, 0);
    step();
    #1;
    chk("t5_first_grant", grant, 4'b0010);
    chk("t5_first_ack", ack, 4'b0010);
    chk("t5_first_data", fifo_data_in, 8'h22);
    step();
    req = '0;
    #1;
    chk("t5_drop_ack", ack, 0);
    chk("t5_drop_wr", fifo_write_en, 0);
    idle_wait();
    fclr = 1'b0;

    // 6: two producers alternate; rr_ptr is 2 after test 5
    grant_seq(4'b0011, 32'h00000121, 3);
    idle_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
